// File: rtl/delta_trig_pkg.sv
// Shared types and constants for the trigger delay measurement block.
// No logic; no latency or backpressure.
package delta_trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int CNT_W_DEF    = 16;
    localparam int AVG_LOG2_MAX = 8;

endpackage

// File: rtl/delta_trig_delay_meas_if.sv
// Trigger/result bundle between a measurement consumer (master) and the meter (slave).
// Wires only; no latency, no backpressure (results are single-cycle pulses).
interface delta_trig_delay_meas_if
    import delta_trig_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             trig_start;
    logic             trig_stop;
    logic [CNT_W-1:0] timeout;
    logic [CNT_W-1:0] delay_out;
    logic             delay_valid;
    logic             timeout_err;
    logic             busy;
`ifdef TRIG_MEAS_MINMAX_EN
    logic [CNT_W-1:0] delay_min;
    logic [CNT_W-1:0] delay_max;

    modport master (output trig_start, trig_stop, timeout,
                    input  delay_out, delay_valid, timeout_err, busy, delay_min, delay_max);
    modport slave  (input  trig_start, trig_stop, timeout,
                    output delay_out, delay_valid, timeout_err, busy, delay_min, delay_max);
`else
    modport master (output trig_start, trig_stop, timeout,
                    input  delay_out, delay_valid, timeout_err, busy);
    modport slave  (input  trig_start, trig_stop, timeout,
                    output delay_out, delay_valid, timeout_err, busy);
`endif
endinterface

// File: rtl/delta_trig_edge_det.sv
// Registered rising-edge detector; rise is combinational in the cycle the input is first high.
// No backpressure.
module delta_trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic x_i,
    output logic rise_o
);
    logic x_q;
    logic arm_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q   <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            x_q   <= x_i;
            arm_q <= 1'b1;
        end
    end

    // arm_q masks the first cycle after reset so a level already high is not an edge
    assign rise_o = x_i & ~x_q & arm_q;

endmodule

// File: rtl/delta_trig_delay_meas.sv
// Start-to-stop latency meter with 2^AVG_LOG2 averaging; result 2 cycles after stop edge, no backpressure.
// Optional min/max sample tracking under TRIG_MEAS_MINMAX_EN.
module delta_trig_delay_meas
    import delta_trig_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int AVG_LOG2 = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    delta_trig_delay_meas_if.slave  bus
);
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((2 ** AVG_LOG2) - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic [CNT_W-1:0] delay_out_q, delay_out_d;
    logic             valid_q, valid_d;
    logic             terr_q, terr_d;
    logic             busy;
    logic             rise_start, rise_stop, tmo_hit;

    delta_trig_edge_det u_start_det (.clk(clk), .rst(rst), .x_i(bus.trig_start), .rise_o(rise_start));
    delta_trig_edge_det u_stop_det  (.clk(clk), .rst(rst), .x_i(bus.trig_stop),  .rise_o(rise_stop));

    // timeout==0 means run to counter saturation, which also prevents wrap
    assign tmo_hit = (bus.timeout != '0) ? (cnt_q == bus.timeout) : (cnt_q == '1);
    assign acc_sum = acc_q + ACC_W'(sample_q);

`ifdef TRIG_MEAS_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sample_q    <= '0;
            acc_q       <= '0;
            smp_q       <= '0;
            delay_out_q <= '0;
            valid_q     <= 1'b0;
            terr_q      <= 1'b0;
`ifdef TRIG_MEAS_MINMAX_EN
            min_q       <= '1;
            max_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            acc_q       <= acc_d;
            smp_q       <= smp_d;
            delay_out_q <= delay_out_d;
            valid_q     <= valid_d;
            terr_q      <= terr_d;
`ifdef TRIG_MEAS_MINMAX_EN
            min_q       <= min_d;
            max_q       <= max_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise_start) state_d = rise_stop ? DONE : COUNT;
            COUNT:   if (rise_stop) state_d = DONE;
                     else if (tmo_hit) state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        acc_d       = acc_q;
        smp_d       = smp_q;
        delay_out_d = delay_out_q;
        valid_d     = 1'b0;
        terr_d      = 1'b0;
        busy        = (state_q == COUNT);
`ifdef TRIG_MEAS_MINMAX_EN
        min_d       = min_q;
        max_d       = max_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise_start) begin
                    cnt_d = CNT_W'(1);
                    if (rise_stop) sample_d = '0;
                end
            end
            COUNT: begin
                if (rise_stop)    sample_d = cnt_q;
                else if (tmo_hit) terr_d   = 1'b1;
                else              cnt_d    = cnt_q + CNT_W'(1);
            end
            DONE: begin
                if (smp_q == SMP_LAST) begin
                    delay_out_d = CNT_W'(acc_sum >> AVG_LOG2);
                    valid_d     = 1'b1;
                    acc_d       = '0;
                    smp_d       = '0;
                end else begin
                    acc_d = acc_sum;
                    smp_d = smp_q + SMP_W'(1);
                end
`ifdef TRIG_MEAS_MINMAX_EN
                if (sample_q < min_q) min_d = sample_q;
                if (sample_q > max_q) max_d = sample_q;
`endif
            end
            default: ;
        endcase
    end

    assign bus.delay_out   = delay_out_q;
    assign bus.delay_valid = valid_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = busy;
`ifdef TRIG_MEAS_MINMAX_EN
    assign bus.delay_min   = min_q;
    assign bus.delay_max   = max_q;
`endif

endmodule

// File: tb/tb_delta_trig_delay_meas.sv
// Directed bench for delta_trig_delay_meas: one instance without averaging, one with AVG_LOG2=2.
module tb_delta_trig_delay_meas;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    delta_trig_delay_meas_if #(.CNT_W(16)) ifc0 ();
    delta_trig_delay_meas_if #(.CNT_W(16)) ifc2 ();

    delta_trig_delay_meas #(.CNT_W(16), .AVG_LOG2(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    delta_trig_delay_meas #(.CNT_W(16), .AVG_LOG2(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // start edge, stop edge n cycles later, then one more cycle so a result is visible
    task automatic run_meas(input bit sel, input int n);
        if (sel) ifc2.trig_start = 1'b1; else ifc0.trig_start = 1'b1;
        step();
        repeat (n - 1) step();
        if (sel) ifc2.trig_stop = 1'b1; else ifc0.trig_stop = 1'b1;
        step();
        if (sel) begin ifc2.trig_start = 1'b0; ifc2.trig_stop = 1'b0; end
        else     begin ifc0.trig_start = 1'b0; ifc0.trig_stop = 1'b0; end
        step();
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int busy_cnt, pulse_cnt;
        ifc0.trig_start = 1'b0; ifc0.trig_stop = 1'b0; ifc0.timeout = 16'd100;
        ifc2.trig_start = 1'b0; ifc2.trig_stop = 1'b0; ifc2.timeout = 16'd100;
        rst = 1'b0;
        repeat (3) step();
        chk("rst_out",   32'(ifc0.delay_out),   32'd0);
        chk("rst_valid", 32'(ifc0.delay_valid), 32'd0);
        chk("rst_terr",  32'(ifc0.timeout_err), 32'd0);
        chk("rst_busy",  32'(ifc0.busy),        32'd0);
        chk("rst_out2",  32'(ifc2.delay_out),   32'd0);
`ifdef TRIG_MEAS_MINMAX_EN
        chk("rst_min",   32'(ifc0.delay_min),   32'd65535);
        chk("rst_max",   32'(ifc0.delay_max),   32'd0);
`endif
        rst = 1'b1;
        step();

        // start and stop rising together
        ifc0.trig_start = 1'b1; ifc0.trig_stop = 1'b1;
        step();
        chk("same_busy",  32'(ifc0.busy),        32'd0);
        step();
        chk("same_valid", 32'(ifc0.delay_valid), 32'd1);
        chk("same_out",   32'(ifc0.delay_out),   32'd0);
        step();
        chk("same_pulse", 32'(ifc0.delay_valid), 32'd0);
        ifc0.trig_start = 1'b0; ifc0.trig_stop = 1'b0;
        step(); step();

        // 37-cycle measurement with busy/valid tracking
        busy_cnt = 0; pulse_cnt = 0;
        ifc0.trig_start = 1'b1;
        step();
        for (int i = 0; i < 37; i++) begin
            if (ifc0.busy) busy_cnt++;
            if (ifc0.delay_valid) pulse_cnt++;
            if (i == 36) ifc0.trig_stop = 1'b1;
            step();
        end
        chk("m37_busy_cycles", 32'(busy_cnt), 32'd37);
        chk("m37_busy_end",    32'(ifc0.busy), 32'd0);
        chk("m37_early_valid", 32'(ifc0.delay_valid + 1'(pulse_cnt != 0)), 32'd0);
        step();
        chk("m37_valid", 32'(ifc0.delay_valid), 32'd1);
        chk("m37_out",   32'(ifc0.delay_out),   32'd37);
        ifc0.trig_start = 1'b0; ifc0.trig_stop = 1'b0;
        step();
        chk("m37_pulse", 32'(ifc0.delay_valid), 32'd0);
        step();

        // timeout of 20 with no stop
        ifc0.timeout = 16'd20;
        pulse_cnt = 0; busy_cnt = 0;
        ifc0.trig_start = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            if (ifc0.timeout_err) busy_cnt++;
            if (ifc0.delay_valid) pulse_cnt++;
            step();
        end
        chk("tmo_early", 32'(busy_cnt), 32'd0);
        chk("tmo_err",   32'(ifc0.timeout_err), 32'd1);
        chk("tmo_busy",  32'(ifc0.busy), 32'd0);
        step();
        chk("tmo_pulse", 32'(ifc0.timeout_err), 32'd0);
        chk("tmo_novalid", 32'(pulse_cnt + 32'(ifc0.delay_valid)), 32'd0);
        chk("tmo_out_held", 32'(ifc0.delay_out), 32'd37);
        ifc0.trig_start = 1'b0;
        ifc0.timeout = 16'd100;
        step();

        // averaging over four samples
        run_meas(1'b1, 10);
        chk("avg_s1_valid", 32'(ifc2.delay_valid), 32'd0);
        run_meas(1'b1, 11);
        chk("avg_s2_valid", 32'(ifc2.delay_valid), 32'd0);
        run_meas(1'b1, 12);
        chk("avg_s3_valid", 32'(ifc2.delay_valid), 32'd0);
        run_meas(1'b1, 14);
        chk("avg_valid", 32'(ifc2.delay_valid), 32'd1);
        chk("avg_out",   32'(ifc2.delay_out),   32'd11);
        step();
        chk("avg_pulse", 32'(ifc2.delay_valid), 32'd0);

        // second start edge during COUNT is ignored
        ifc0.trig_start = 1'b1;
        step(); step(); step();
        ifc0.trig_start = 1'b0;
        step(); step();
        ifc0.trig_start = 1'b1;
        step(); step(); step();
        ifc0.trig_stop = 1'b1;
        step();
        chk("retrig_busy", 32'(ifc0.busy), 32'd0);
        step();
        chk("retrig_valid", 32'(ifc0.delay_valid), 32'd1);
        chk("retrig_out",   32'(ifc0.delay_out),   32'd8);
        ifc0.trig_start = 1'b0; ifc0.trig_stop = 1'b0;
        step(); step();

        // reset mid-COUNT, then hold start high across release
        ifc0.trig_start = 1'b1;
        step();
        repeat (3) step();
        chk("mid_busy", 32'(ifc0.busy), 32'd1);
        rst = 1'b0;
        step();
        chk("mid_rst_busy", 32'(ifc0.busy),        32'd0);
        chk("mid_rst_out",  32'(ifc0.delay_out),   32'd0);
        chk("mid_rst_out2", 32'(ifc2.delay_out),   32'd0);
        chk("mid_rst_valid",32'(ifc0.delay_valid), 32'd0);
        rst = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ifc0.busy) busy_cnt++;
        end
        chk("held_start_busy", 32'(busy_cnt), 32'd0);
        ifc0.trig_start = 1'b0;
        step(); step();

`ifdef TRIG_MEAS_MINMAX_EN
        run_meas(1'b0, 30);
        run_meas(1'b0, 5);
        run_meas(1'b0, 18);
        step();
        chk("mm_min", 32'(ifc0.delay_min), 32'd5);
        chk("mm_max", 32'(ifc0.delay_max), 32'd30);
        ifc0.timeout = 16'd3;
        ifc0.trig_start = 1'b1;
        repeat (8) step();
        ifc0.trig_start = 1'b0;
        step();
        chk("mm_tmo_min", 32'(ifc0.delay_min), 32'd5);
        chk("mm_tmo_max", 32'(ifc0.delay_max), 32'd30);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delta_trig_delay_meas.md
Name: delta_trig_delay_meas

Overview:
- Measures the clock-cycle latency between a launched trigger (trig_start) and the trigger returned by the delay path or front-end (trig_stop).
- Sits at the opposite end of the trigger delay chain from delta_trig_delay. Used to calibrate and verify programmed delays and cable/board latency.
- Optionally averages 2^AVG_LOG2 samples before reporting. Reports timeouts when no stop arrives.

Parameters:
- CNT_W, 16, width of the delay counter and the result.
- AVG_LOG2, 0, log2 of the number of samples averaged per reported result (range 0..8).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low.
- trig_start  input  1  launched trigger; level input, rising edge is used.
- trig_stop  input  1  returned trigger; level input, rising edge is used.
- timeout  input  CNT_W  max cycles to wait for stop; 0 = wait until counter saturates.
- delay_out  output  CNT_W  measured (averaged) delay in cycles; holds its value between results.
- delay_valid  output  1  one-cycle pulse when delay_out updates.
- timeout_err  output  1  one-cycle pulse when a measurement is abandoned.
- busy  output  1  high while in COUNT.

Behaviour:
- Reset is decided: one clock `clk`; reset `rst` is synchronous and active-low. While rst==0 at a clk edge:
  - All outputs are cleared to 0.
  - The state machine goes to IDLE.
  - The counter, accumulator and sample counter are cleared.
  - The edge-detect registers are cleared, so a level already high at reset release does not count as an edge.
  - Reset mid-measurement discards the partial count and the accumulated samples.
- Edge detection: rise_x = x & ~x_q, where x_q is x registered. Edges are evaluated in the cycle the input is first sampled high.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - On rise_start: cnt<=1 and go to COUNT.
  - If rise_stop occurs in the same cycle as rise_start: the sample = 0; go to DONE.
  - rise_stop alone is ignored.
- COUNT:
  - Each cycle without rise_stop, cnt<=cnt+1.
  - On rise_stop: the sample = cnt, which equals the number of cycles between the start-edge cycle and the stop-edge cycle; go to DONE.
  - rise_start while in COUNT is ignored; there is no retrigger.
  - Timeout when timeout!=0 and cnt==timeout with no rise_stop in that cycle, or when timeout==0 and cnt==all-ones. Then:
    - timeout_err pulses next cycle;
    - the sample is discarded and the accumulator is unchanged;
    - the FSM returns to IDLE.
  - If rise_stop and the timeout condition coincide, the stop wins and the sample is taken.
- DONE (one cycle):
  - acc<=acc+sample; acc width is CNT_W+AVG_LOG2, so it cannot overflow.
  - smp<=smp+1.
  - When smp reaches 2^AVG_LOG2-1 before the increment:
    - delay_out<=(acc+sample)>>AVG_LOG2, truncating;
    - delay_valid=1 for one cycle;
    - acc and smp cleared.
  - Always returns to IDLE. A start edge arriving during DONE is lost.
- Latency: with AVG_LOG2=0, delay_valid is asserted 2 cycles after the stop-edge cycle. Back-to-back measurements need trig_start to go low and then rise again.
- busy=1 exactly while state==COUNT.

Optional Feature:
- Macro TRIG_MEAS_MINMAX_EN.
- When defined, two extra outputs are added: delay_min and delay_max, both CNT_W wide.
  - They track the min and max of individual non-discarded samples since reset.
  - They update in the DONE cycle and are visible the cycle after.
  - Reset values: min = all-ones, max = 0.
- When undefined, these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package delta_trig_pkg holds:
  - the state enum {IDLE, COUNT, DONE} as a 2-bit typedef;
  - the CNT_W default constant;
  - the AVG_LOG2 upper-bound constant.
- One natural sub-module, delta_trig_edge_det: a registered rising-edge detector with sync active-low reset. It is instantiated twice, once for start and once for stop.

Test Plan:
- AVG_LOG2=0, timeout=100; start edge at cycle 10, stop edge at cycle 47 -> delay_out=37, delay_valid pulses once at cycle 49, busy high cycles 11..47.
- Start and stop rising in the same cycle -> delay_out=0, delay_valid pulses once.
- timeout=20, no stop -> timeout_err pulses once 21 cycles after the start edge, delay_valid stays 0, and delay_out keeps its previous value.
- AVG_LOG2=2; samples 10, 11, 12, 14 -> a single delay_valid with delay_out=11 (47>>2). No valid is asserted after the first three samples.
- A second start edge during COUNT, and rst=0 asserted mid-COUNT -> the second edge is ignored; on reset, outputs clear, the FSM returns to IDLE, and a held-high trig_start after release does not start a measurement.
- With TRIG_MEAS_MINMAX_EN: samples 30, 5, 18 -> delay_min=5, delay_max=30. A timed-out sample leaves both unchanged.
